uart_cmd_ctrl: RTL and testbench

//  Command responder at the far end of the UART link. Consumes bytes from the

---
 rtl/uart_cmd_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command responder behind the UART: decodes write/read/ALU frames, drives the
// register file and ALU, and returns result bytes (LSB first) to the transmitter.
module uart_cmd_ctrl #(
    parameter int               WIDTH      = 8,
    parameter int               ADDR_W     = 4,
    parameter logic [WIDTH-1:0] CMD_WR     = 8'hAA,
    parameter logic [WIDTH-1:0] CMD_RD     = 8'hBB,
    parameter logic [WIDTH-1:0] CMD_ALU_OP = 8'hCC,
    parameter logic [WIDTH-1:0] CMD_ALU_NP = 8'hDD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     rx_data,
    input  logic                 rx_valid,
    input  logic                 tx_busy,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_valid,
    output logic [ADDR_W-1:0]    rf_addr,
    output logic [WIDTH-1:0]     rf_wr_data,
    output logic                 rf_wr_en,
    output logic                 rf_rd_en,
    input  logic [WIDTH-1:0]     rf_rd_data,
    input  logic                 rf_rd_valid,
    output logic [3:0]           alu_fun,
    output logic                 alu_en,
    input  logic [2*WIDTH-1:0]   alu_out,
    input  logic                 alu_out_valid
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OP_A, OP_B, OP_FUN, ALU_WAIT, TX_SEND, TX_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [2*WIDTH-1:0]  res_q, res_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                busy_seen_q, busy_seen_d;
    logic [WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic                rf_rd_en_q, rf_rd_en_d;
    logic [3:0]          alu_fun_q, alu_fun_d;
    logic                alu_en_q, alu_en_d;

    logic                launch;
    logic [2*WIDTH-1:0]  src_val;
    logic [1:0]          src_n;

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        busy_seen_d  = busy_seen_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        launch       = 1'b0;
        src_val      = res_q;
        src_n        = cnt_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR)          state_d = WR_ADDR;
                    else if (rx_data == CMD_RD)     state_d = RD_ADDR;
                    else if (rx_data == CMD_ALU_OP) state_d = OP_A;
                    else if (rx_data == CMD_ALU_NP) state_d = OP_FUN;
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_W-1:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_valid) begin
                    src_val = {{WIDTH{1'b0}}, rf_rd_data};
                    src_n   = 2'd1;
                    res_d   = src_val;
                    cnt_d   = src_n;
                    state_d = TX_SEND;
                    launch  = !tx_busy;
                end
            end
            OP_A: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(0);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = OP_B;
                end
            end
            OP_B: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(1);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = OP_FUN;
                end
            end
            OP_FUN: begin
                if (rx_valid) begin
                    alu_fun_d = rx_data[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (alu_out_valid) begin
                    src_val = alu_out;
                    src_n   = 2'd2;
                    res_d   = src_val;
                    cnt_d   = src_n;
                    state_d = TX_SEND;
                    launch  = !tx_busy;
                end
            end
            TX_SEND: begin
                launch = !tx_busy;
            end
            TX_WAIT: begin
                // A byte is finished only after busy has been seen rising and then falling.
                if (!busy_seen_q) begin
                    if (tx_busy) busy_seen_d = 1'b1;
                end else if (!tx_busy) begin
                    state_d = (cnt_q != 2'd0) ? TX_SEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is shifted down one byte per transmit so the LSB always goes first.
        if (launch) begin
            tx_valid_d  = 1'b1;
            tx_data_d   = src_val[WIDTH-1:0];
            res_d       = src_val >> WIDTH;
            cnt_d       = src_n - 2'd1;
            busy_seen_d = 1'b0;
            state_d     = TX_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            res_q        <= '0;
            cnt_q        <= '0;
            busy_seen_q  <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            busy_seen_q  <= busy_seen_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign alu_fun    = alu_fun_q;
    assign alu_en     = alu_en_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame vectors with hand-computed responses, plus
// hand-written sequences for reset during a wait, write latency and rx during TX_WAIT.
module tb_uart_cmd_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_out_valid;

    uart_cmd_ctrl dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
        .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_fun(alu_fun), .alu_en(alu_en),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    typedef struct {
        logic [31:0] bytes;  // frame bytes, first byte in [31:24]
        int          n;
        logic [15:0] resp;   // read data (low byte) or ALU result
        int          wr_n;
        logic [11:0] wr0;    // {addr, data}
        logic [11:0] wr1;
        int          rd_n;
        logic [3:0]  rd_a;
        int          alu_n;
        logic [3:0]  fun;
        int          tx_n;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
    } vec_t;

    function automatic vec_t mk(logic [31:0] bytes, int n, logic [15:0] resp,
                                int wr_n, logic [11:0] wr0, logic [11:0] wr1,
                                int rd_n, logic [3:0] rd_a, int alu_n, logic [3:0] fun,
                                int tx_n, logic [7:0] tx0, logic [7:0] tx1);
        vec_t v;
        v.bytes = bytes; v.n = n; v.resp = resp;
        v.wr_n = wr_n; v.wr0 = wr0; v.wr1 = wr1;
        v.rd_n = rd_n; v.rd_a = rd_a; v.alu_n = alu_n; v.fun = fun;
        v.tx_n = tx_n; v.tx0 = tx0; v.tx1 = tx1;
        return v;
    endfunction

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] wr_got[$];
    logic [3:0]  rd_got[$];
    logic [3:0]  alu_got[$];
    logic [7:0]  tx_got[$];
    logic [7:0]  exp_q[$];

    logic [15:0] resp_val;
    logic        auto_resp;
    int          alu_req;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- register file / ALU / UART tx models and monitor ----------------
    initial begin
        int rd_cd;
        int alu_cd;
        int busy_cd;
        int alu_ack;
        rd_cd = 0; alu_cd = 0; busy_cd = 0; alu_ack = 0;
        rf_rd_valid = 1'b0; rf_rd_data = 8'h00;
        alu_out_valid = 1'b0; alu_out = 16'h0000;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rf_wr_en) wr_got.push_back({rf_addr, rf_wr_data});
            if (rf_rd_en) rd_got.push_back(rf_addr);
            if (alu_en)   alu_got.push_back(alu_fun);
            if (tx_valid) begin
                check("tx_while_busy", {31'd0, tx_busy}, 32'd0);
                tx_got.push_back(tx_data);
            end

            rf_rd_valid   = 1'b0;
            alu_out_valid = 1'b0;
            if (rd_cd != 0) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    rf_rd_valid = 1'b1;
                    rf_rd_data  = resp_val[7:0];
                end
            end
            if (alu_cd != 0) begin
                alu_cd--;
                if (alu_cd == 0) begin
                    alu_out_valid = 1'b1;
                    alu_out       = resp_val;
                end
            end
            if (alu_req != alu_ack) begin
                alu_ack       = alu_req;
                alu_out_valid = 1'b1;
                alu_out       = resp_val;
            end
            if (auto_resp && rf_rd_en) rd_cd = 2;
            if (auto_resp && alu_en)   alu_cd = 3;

            if (busy_cd != 0) begin
                busy_cd--;
                tx_busy = (busy_cd != 0);
            end
            if (tx_valid) begin
                tx_busy = 1'b1;
                busy_cd = 4;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_caps();
        wr_got.delete();
        rd_got.delete();
        alu_got.delete();
        tx_got.delete();
    endtask

    task automatic compare_vec(input string tag, input vec_t v);
        check({tag, " wr_count"}, wr_got.size(), v.wr_n);
        if (v.wr_n > 0 && wr_got.size() > 0) check({tag, " wr0"}, {20'd0, wr_got[0]}, {20'd0, v.wr0});
        if (v.wr_n > 1 && wr_got.size() > 1) check({tag, " wr1"}, {20'd0, wr_got[1]}, {20'd0, v.wr1});
        check({tag, " rd_count"}, rd_got.size(), v.rd_n);
        if (v.rd_n > 0 && rd_got.size() > 0) check({tag, " rd_addr"}, {28'd0, rd_got[0]}, {28'd0, v.rd_a});
        check({tag, " alu_count"}, alu_got.size(), v.alu_n);
        if (v.alu_n > 0 && alu_got.size() > 0) check({tag, " alu_fun"}, {28'd0, alu_got[0]}, {28'd0, v.fun});
        exp_q.delete();
        if (v.tx_n > 0) exp_q.push_back(v.tx0);
        if (v.tx_n > 1) exp_q.push_back(v.tx1);
        check({tag, " tx_count"}, tx_got.size(), v.tx_n);
        while (exp_q.size() > 0 && tx_got.size() > 0) begin
            logic [7:0] g;
            logic [7:0] e;
            g = tx_got.pop_front();
            e = exp_q.pop_front();
            check({tag, " tx_byte"}, {24'd0, g}, {24'd0, e});
        end
        clear_caps();
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        resp_val = v.resp;
        for (int j = 0; j < v.n; j++) begin
            logic [31:0] bs;
            bs = v.bytes;
            send_byte(bs[31-8*j -: 8]);
        end
        repeat (60) @(negedge clk);
        compare_vec(tag, v);
    endtask

    function automatic logic [31:0] outs_now();
        return {4'd0, tx_valid, tx_data, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en};
    endfunction

    // ---------------- main test ----------------
    vec_t vecs[8];

    initial begin
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        reset     = 1'b1;
        resp_val  = 16'h0000;
        auto_resp = 1'b1;
        alu_req   = 0;

        vecs[0] = mk(32'hAA053C00, 3, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        vecs[1] = mk(32'hBB050000, 2, 16'h003C, 0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00);
        vecs[2] = mk(32'hCC102000, 4, 16'h0030, 2, 12'h010, 12'h120, 0, 4'h0, 1, 4'h0, 2, 8'h30, 8'h00);
        vecs[3] = mk(32'h55DD0200, 3, 16'hABCD, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h2, 2, 8'hCD, 8'hAB);
        vecs[4] = mk(32'hAA1F7E00, 3, 16'h0000, 1, 12'hF7E, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        vecs[5] = mk(32'hDD1A0000, 2, 16'h1234, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'hA, 2, 8'h34, 8'h12);
        vecs[6] = mk(32'hBB030000, 2, 16'h0099, 0, 12'h000, 12'h000, 1, 4'h3, 0, 4'h0, 1, 8'h99, 8'h00);
        vecs[7] = mk(32'hCCFF01F3, 4, 16'h0100, 2, 12'h0FF, 12'h101, 0, 4'h0, 1, 4'h3, 2, 8'h00, 8'h01);

        repeat (3) @(negedge clk);
        check("reset_outputs", outs_now(), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Write strobe lands exactly one cycle after the DATA byte and lasts one cycle.
        send_byte(8'hAA);
        send_byte(8'h06);
        @(negedge clk);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("wr_latency_en", {31'd0, rf_wr_en}, 32'd1);
        check("wr_latency_addr", {28'd0, rf_addr}, 32'h6);
        check("wr_latency_data", {24'd0, rf_wr_data}, 32'h11);
        @(negedge clk);
        check("wr_one_cycle", {31'd0, rf_wr_en}, 32'd0);
        repeat (5) @(negedge clk);
        clear_caps();

        // Reset while waiting for the ALU: late result must not be transmitted.
        auto_resp = 1'b0;
        resp_val  = 16'h7777;
        send_byte(8'hDD);
        send_byte(8'h03);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", outs_now(), 32'd0);
        reset = 1'b0;
        alu_req = alu_req + 1;
        repeat (30) @(negedge clk);
        compare_vec("reset_alu", mk(32'h0, 0, 16'h0, 0, 12'h0, 12'h0, 0, 4'h0, 1, 4'h3, 0, 8'h00, 8'h00));
        auto_resp = 1'b1;
        run_vec("after_reset", mk(32'hAA025500, 3, 16'h0000, 1, 12'h255, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00));

        // A command byte arriving in TX_WAIT is dropped; the response finishes unchanged.
        begin
            int guard;
            resp_val = 16'h0102;
            send_byte(8'hDD);
            send_byte(8'h05);
            guard = 0;
            while (tx_got.size() == 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("tx_start_timeout", {31'd0, tx_got.size() > 0}, 32'd1);
            send_byte(8'hBB);
            repeat (60) @(negedge clk);
            compare_vec("rx_in_txwait", mk(32'h0, 0, 16'h0, 0, 12'h0, 12'h0, 0, 4'h0, 1, 4'h5, 2, 8'h02, 8'h01));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
